// File: rtl/axil_arbiter_2to1_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) shared by managers and subordinate.
interface axil_arbiter_2to1_if #(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32
);
  logic [AXI_AWIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DWIDTH-1:0]   wdata;
  logic [AXI_DWIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_AWIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_DWIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_arbiter_2to1.sv
// Two-manager AXI4-Lite arbiter: independent round-robin read and write paths,
// one outstanding transaction per direction, registered grant, combinational
// pass-through of the granted manager while a transaction is in flight.
module axil_arbiter_2to1 #(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                CLK,
  input  logic                NRST,
  axil_arbiter_2to1_if.slave  m0,
  axil_arbiter_2to1_if.slave  m1,
  axil_arbiter_2to1_if.master s
);
  localparam int SW = AXI_DWIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  logic     wg_q, wg_d, wr_ptr_q, wr_ptr_d;
  logic     aw_done_q, aw_done_d, w_done_q, w_done_d;
  r_state_e r_state_q, r_state_d;
  logic     rg_q, rg_d, rd_ptr_q, rd_ptr_d;

  logic [AXI_AWIDTH-1:0] g_awaddr, g_araddr;
  logic [AXI_DWIDTH-1:0] g_wdata;
  logic [SW-1:0]         g_wstrb;
  logic                  g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Select the granted manager's request signals and detect subordinate handshakes
  always_comb begin
    g_awaddr  = wg_q ? m1.awaddr  : m0.awaddr;
    g_awvalid = wg_q ? m1.awvalid : m0.awvalid;
    g_wdata   = wg_q ? m1.wdata   : m0.wdata;
    g_wstrb   = wg_q ? m1.wstrb   : m0.wstrb;
    g_wvalid  = wg_q ? m1.wvalid  : m0.wvalid;
    g_bready  = wg_q ? m1.bready  : m0.bready;
    g_araddr  = rg_q ? m1.araddr  : m0.araddr;
    g_arvalid = rg_q ? m1.arvalid : m0.arvalid;
    g_rready  = rg_q ? m1.rready  : m0.rready;
    aw_hs = (w_state_q == W_ADDR) & g_awvalid & ~aw_done_q & s.awready;
    w_hs  = (w_state_q == W_ADDR) & g_wvalid  & ~w_done_q  & s.wready;
    b_hs  = (w_state_q == W_RESP) & s.bvalid  & g_bready;
    ar_hs = (r_state_q == R_ADDR) & g_arvalid & s.arready;
    r_hs  = (r_state_q == R_DATA) & s.rvalid  & g_rready;
  end

  // Write FSM next state: arbitrate on AWVALID, collect AW and W in any order, wait for B
  always_comb begin
    w_state_d = w_state_q;
    wg_d      = wg_q;
    wr_ptr_d  = wr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (m0.awvalid | m1.awvalid) begin
          wg_d      = (m0.awvalid & m1.awvalid) ? wr_ptr_q : m1.awvalid;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // done_d folds in this cycle's handshakes, so a joint AW/W beat moves on at once
        if (aw_done_d & w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wr_ptr_d  = ~wg_q;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM state, grant, pointer and completion flags
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      w_state_q <= W_IDLE;
      wg_q      <= 1'b0;
      wr_ptr_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wg_q      <= wg_d;
      wr_ptr_q  <= wr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Read FSM next state: arbitrate on ARVALID, forward AR, wait for R
  always_comb begin
    r_state_d = r_state_q;
    rg_d      = rg_q;
    rd_ptr_d  = rd_ptr_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (m0.arvalid | m1.arvalid) begin
          rg_d      = (m0.arvalid & m1.arvalid) ? rd_ptr_q : m1.arvalid;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: if (ar_hs) r_state_d = R_DATA;
      R_DATA: begin
        if (r_hs) begin
          r_state_d = R_IDLE;
          rd_ptr_d  = ~rg_q;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM state, grant and pointer
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state_q <= R_IDLE;
      rg_q      <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rg_q      <= rg_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Write-side routing: only the granted manager sees anything, everything else is zero
  always_comb begin
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m0.bresp   = '0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;
    m1.bresp   = '0;
    s.awaddr   = '0;
    s.awvalid  = 1'b0;
    s.wdata    = '0;
    s.wstrb    = '0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    if (w_state_q == W_ADDR) begin
      s.awaddr  = g_awaddr;
      s.awvalid = g_awvalid & ~aw_done_q;
      s.wdata   = g_wdata;
      s.wstrb   = g_wstrb;
      s.wvalid  = g_wvalid & ~w_done_q;
      if (wg_q) begin
        m1.awready = s.awready & ~aw_done_q;
        m1.wready  = s.wready & ~w_done_q;
      end else begin
        m0.awready = s.awready & ~aw_done_q;
        m0.wready  = s.wready & ~w_done_q;
      end
    end
    if (w_state_q == W_RESP) begin
      s.bready = g_bready;
      if (wg_q) begin
        m1.bvalid = s.bvalid;
        m1.bresp  = s.bresp;
      end else begin
        m0.bvalid = s.bvalid;
        m0.bresp  = s.bresp;
      end
    end
  end

  // Read-side routing: only the granted manager sees anything, everything else is zero
  always_comb begin
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    s.araddr   = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    if (r_state_q == R_ADDR) begin
      s.araddr  = g_araddr;
      s.arvalid = g_arvalid;
      if (rg_q) m1.arready = s.arready;
      else      m0.arready = s.arready;
    end
    if (r_state_q == R_DATA) begin
      s.rready = g_rready;
      if (rg_q) begin
        m1.rvalid = s.rvalid;
        m1.rdata  = s.rdata;
        m1.rresp  = s.rresp;
      end else begin
        m0.rvalid = s.rvalid;
        m0.rdata  = s.rdata;
        m0.rresp  = s.rresp;
      end
    end
  end
endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Bench for axil_arbiter_2to1: two task-driven managers, a behavioural subordinate
// with a small memory, and queues of expected B/R responses checked as they arrive.
module tb_axil_arbiter_2to1;
  logic CLK = 1'b0;
  logic NRST = 1'b0;
  always #5 CLK = ~CLK;

  axil_arbiter_2to1_if #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) m0_if ();
  axil_arbiter_2to1_if #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) m1_if ();
  axil_arbiter_2to1_if #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) s_if ();

  axil_arbiter_2to1 #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) dut (
    .CLK(CLK), .NRST(NRST), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  // Manager-side drive, indexed by manager number
  logic [3:0]  awaddr_r [2];
  logic [3:0]  araddr_r [2];
  logic [31:0] wdata_r  [2];
  logic [3:0]  wstrb_r  [2];
  logic [1:0]  awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
  assign m0_if.awaddr = awaddr_r[0];  assign m1_if.awaddr = awaddr_r[1];
  assign m0_if.awvalid = awvalid_r[0]; assign m1_if.awvalid = awvalid_r[1];
  assign m0_if.wdata = wdata_r[0];    assign m1_if.wdata = wdata_r[1];
  assign m0_if.wstrb = wstrb_r[0];    assign m1_if.wstrb = wstrb_r[1];
  assign m0_if.wvalid = wvalid_r[0];  assign m1_if.wvalid = wvalid_r[1];
  assign m0_if.bready = bready_r[0];  assign m1_if.bready = bready_r[1];
  assign m0_if.araddr = araddr_r[0];  assign m1_if.araddr = araddr_r[1];
  assign m0_if.arvalid = arvalid_r[0]; assign m1_if.arvalid = arvalid_r[1];
  assign m0_if.rready = rready_r[0];  assign m1_if.rready = rready_r[1];

  logic [1:0]  awready_w, arready_w, bvalid_w, rvalid_w;
  logic [1:0]  bresp_w [2];
  logic [1:0]  rresp_w [2];
  logic [31:0] rdata_w [2];
  assign awready_w = {m1_if.awready, m0_if.awready};
  assign arready_w = {m1_if.arready, m0_if.arready};
  assign bvalid_w  = {m1_if.bvalid, m0_if.bvalid};
  assign rvalid_w  = {m1_if.rvalid, m0_if.rvalid};
  assign bresp_w[0] = m0_if.bresp; assign bresp_w[1] = m1_if.bresp;
  assign rresp_w[0] = m0_if.rresp; assign rresp_w[1] = m1_if.rresp;
  assign rdata_w[0] = m0_if.rdata; assign rdata_w[1] = m1_if.rdata;

  logic m1_out_any, dut_out_any;
  assign m1_out_any = |{m1_if.awready, m1_if.wready, m1_if.bresp, m1_if.bvalid,
                        m1_if.arready, m1_if.rdata, m1_if.rresp, m1_if.rvalid};
  assign dut_out_any = m1_out_any |
                       (|{m0_if.awready, m0_if.wready, m0_if.bresp, m0_if.bvalid,
                          m0_if.arready, m0_if.rdata, m0_if.rresp, m0_if.rvalid}) |
                       (|{s_if.awaddr, s_if.awvalid, s_if.wdata, s_if.wstrb, s_if.wvalid,
                          s_if.bready, s_if.araddr, s_if.arvalid, s_if.rready});

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed { logic id; logic [31:0] data; logic [1:0] resp; } rd_exp_t;
  typedef struct packed { logic id; logic [1:0] resp; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  // Behavioural subordinate: 16-word memory, optional AWREADY delay,
  // SLVERR (no write) at 0xF, DECERR on reads of 0xE
  logic [31:0] mem [16];
  int aw_delay = 0;
  int aw_wait, n_aw, n_w;
  bit have_aw, have_w, have_ar, b_fire, r_fire, ar_fire;
  logic [3:0]  sa_aw, sa_ar;
  logic [31:0] sw_d;
  logic [3:0]  sw_s;

  initial begin : sub_model
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    {have_aw, have_w, have_ar} = '0;
    aw_wait = 0; n_aw = 0; n_w = 0;
    {s_if.awready, s_if.wready, s_if.bvalid, s_if.arready, s_if.rvalid} = '0;
    s_if.bresp = '0; s_if.rresp = '0; s_if.rdata = '0;
    forever begin
      @(negedge CLK);
      if (s_if.awvalid && s_if.awready) begin
        have_aw = 1; sa_aw = s_if.awaddr; n_aw++; aw_wait = 0;
      end else if (s_if.awvalid) aw_wait++;
      if (s_if.wvalid && s_if.wready) begin
        have_w = 1; sw_d = s_if.wdata; sw_s = s_if.wstrb; n_w++;
      end
      b_fire  = s_if.bvalid && s_if.bready;
      ar_fire = s_if.arvalid && s_if.arready;
      r_fire  = s_if.rvalid && s_if.rready;
      if (ar_fire) sa_ar = s_if.araddr;
      @(posedge CLK); #1;
      if (!NRST) begin
        {have_aw, have_w, have_ar} = '0;
        aw_wait = 0;
        {s_if.bvalid, s_if.rvalid} = '0;
      end else begin
        if (b_fire) begin s_if.bvalid = 0; have_aw = 0; have_w = 0; end
        if (r_fire) begin s_if.rvalid = 0; have_ar = 0; end
        if (ar_fire) begin
          have_ar = 1; s_if.rvalid = 1; s_if.rdata = mem[sa_ar];
          s_if.rresp = (sa_ar == 4'hE) ? 2'b11 : 2'b00;
        end
        if (have_aw && have_w && !s_if.bvalid && !b_fire) begin
          if (sa_aw != 4'hF)
            for (int b = 0; b < 4; b++) if (sw_s[b]) mem[sa_aw][8*b +: 8] = sw_d[8*b +: 8];
          s_if.bvalid = 1; s_if.bresp = (sa_aw == 4'hF) ? 2'b10 : 2'b00;
        end
      end
      s_if.awready = !have_aw && (aw_wait >= aw_delay);
      s_if.wready  = !have_w;
      s_if.arready = !have_ar;
    end
  end

  // Response monitors: pop the expected entry whenever a manager completes B or R
  always @(negedge CLK) begin : resp_mon
    rd_exp_t re;
    wr_exp_t we;
    for (int i = 0; i < 2; i++) begin
      if (rvalid_w[i] && rready_r[i]) begin
        if (rd_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = rd_q.pop_front();
          chk("r_mgr", i, re.id);
          chk("r_data", rdata_w[i], re.data);
          chk("r_resp", rresp_w[i], re.resp);
        end
      end
      if (bvalid_w[i] && bready_r[i]) begin
        if (wr_q.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          we = wr_q.pop_front();
          chk("b_mgr", i, we.id);
          chk("b_resp", bresp_w[i], we.resp);
        end
      end
    end
  end

  bit m1_quiet_chk = 0;
  always @(negedge CLK) if (m1_quiet_chk) chk("m1_outputs_quiet", m1_out_any, 0);

  // Called just after a rising edge; W is raised w_lead cycles before AW
  task automatic mgr_write(input int id, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] st, input int w_lead, input int b_hold);
    bit aw_ok, w_ok, b_ok;
    wdata_r[id] = d; wstrb_r[id] = st; wvalid_r[id] = 1'b1;
    if (w_lead > 0) begin repeat (w_lead) @(posedge CLK); #1; end
    awaddr_r[id] = a; awvalid_r[id] = 1'b1;
    aw_ok = 0; w_ok = 0;
    for (int c = 0; c < 100 && !(aw_ok && w_ok); c++) begin
      @(negedge CLK);
      if (awvalid_r[id] && awready_w[id]) aw_ok = 1;
      if (wvalid_r[id] && (id == 0 ? m0_if.wready : m1_if.wready)) w_ok = 1;
      @(posedge CLK); #1;
      if (aw_ok) awvalid_r[id] = 1'b0;
      if (w_ok) wvalid_r[id] = 1'b0;
    end
    if (!(aw_ok && w_ok)) begin
      chk("aw_w_timeout", 0, 1); awvalid_r[id] = 1'b0; wvalid_r[id] = 1'b0; return;
    end
    b_ok = 0;
    for (int c = 0; c < 100 && !b_ok; c++) begin
      @(negedge CLK); b_ok = bvalid_w[id]; @(posedge CLK); #1;
    end
    if (!b_ok) begin chk("b_timeout", 0, 1); return; end
    repeat (b_hold) begin
      @(negedge CLK); chk("b_held_while_not_ready", bvalid_w[id], 1); @(posedge CLK); #1;
    end
    bready_r[id] = 1'b1;
    @(negedge CLK); @(posedge CLK); #1;
    bready_r[id] = 1'b0;
  endtask

  task automatic mgr_read(input int id, input logic [3:0] a);
    bit ok;
    araddr_r[id] = a; arvalid_r[id] = 1'b1; ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge CLK); ok = arvalid_r[id] && arready_w[id]; @(posedge CLK); #1;
    end
    arvalid_r[id] = 1'b0;
    if (!ok) begin chk("ar_timeout", 0, 1); return; end
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge CLK); ok = rvalid_w[id]; @(posedge CLK); #1;
    end
    if (!ok) begin chk("r_timeout", 0, 1); return; end
    rready_r[id] = 1'b1;
    @(negedge CLK); @(posedge CLK); #1;
    rready_r[id] = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    int aw0, w0;
    for (int i = 0; i < 2; i++) begin
      awaddr_r[i] = '0; araddr_r[i] = '0; wdata_r[i] = '0; wstrb_r[i] = '0;
    end
    {awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r} = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); chk("reset_outputs_zero", dut_out_any, 0);
    NRST = 1'b1;
    @(negedge CLK); chk("idle_outputs_zero", dut_out_any, 0);
    @(posedge CLK); #1;

    // 1: single M0 write, forwarded one cycle after the request
    wr_q.push_back('{id: 1'b0, resp: 2'b00});
    m1_quiet_chk = 1;
    fork
      mgr_write(0, 4'h4, 32'hDEAD_BEEF, 4'hF, 0, 0);
      begin
        @(negedge CLK); chk("t1_no_fwd_in_grant_cycle", s_if.awvalid, 0);
        @(negedge CLK); chk("t1_s_awvalid", s_if.awvalid, 1);
        chk("t1_s_awaddr", s_if.awaddr, 4'h4);
        chk("t1_s_wvalid", s_if.wvalid, 1);
        chk("t1_s_wdata", s_if.wdata, 32'hDEAD_BEEF);
        chk("t1_s_wstrb", s_if.wstrb, 4'hF);
      end
    join
    m1_quiet_chk = 0;

    // 2: contested reads after reset go M0 then M1. Once M1 has been served the
    // pointer favours M0 again, so a lone M0 read hands priority to M1.
    rd_q.push_back('{id: 1'b0, data: 32'h1000_0000, resp: 2'b00});
    rd_q.push_back('{id: 1'b1, data: 32'h1000_0008, resp: 2'b00});
    fork mgr_read(0, 4'h0); mgr_read(1, 4'h8); join
    rd_q.push_back('{id: 1'b0, data: 32'h1000_000E, resp: 2'b11});
    mgr_read(0, 4'hE);
    rd_q.push_back('{id: 1'b1, data: 32'h1000_0008, resp: 2'b00});
    rd_q.push_back('{id: 1'b0, data: 32'h1000_0000, resp: 2'b00});
    fork mgr_read(0, 4'h0); mgr_read(1, 4'h8); join

    // 3: M1 W leads AW by 3 cycles, subordinate AWREADY delayed 2 cycles
    aw_delay = 2; aw0 = n_aw; w0 = n_w;
    wr_q.push_back('{id: 1'b1, resp: 2'b00});
    mgr_write(1, 4'hC, 32'h1234_5678, 4'h3, 3, 0);
    chk("t3_single_aw", n_aw - aw0, 1);
    chk("t3_single_w", n_w - w0, 1);
    aw_delay = 0;

    // 4: M0 holds BREADY low; M1 must not get AWREADY meanwhile
    wr_q.push_back('{id: 1'b0, resp: 2'b00});
    wr_q.push_back('{id: 1'b1, resp: 2'b00});
    fork
      mgr_write(0, 4'h2, 32'h0BAD_CAFE, 4'hF, 0, 5);
      begin @(posedge CLK); #1; mgr_write(1, 4'h3, 32'h0000_0055, 4'h1, 0, 0); end
      begin
        for (int c = 0; c < 50 && !bvalid_w[0]; c++) @(negedge CLK);
        repeat (4) begin
          chk("t4_m1_awready_blocked", awready_w[1], 0);
          @(negedge CLK);
        end
      end
    join

    // 5: M0 read and M1 write together; read sees the strobed write of test 3
    rd_q.push_back('{id: 1'b0, data: 32'h1000_5678, resp: 2'b00});
    wr_q.push_back('{id: 1'b1, resp: 2'b10});
    fork mgr_read(0, 4'hC); mgr_write(1, 4'hF, 32'hCAFE_F00D, 4'hF, 0, 0); join

    // 6: reset during R_DATA (read pointer currently favours M1)
    araddr_r[0] = 4'h0; arvalid_r[0] = 1'b1;
    @(negedge CLK);
    @(negedge CLK); chk("t6_s_arvalid", s_if.arvalid, 1);
    @(posedge CLK); #1; arvalid_r[0] = 1'b0;
    @(negedge CLK); chk("t6_rvalid_in_r_data", rvalid_w[0], 1);
    NRST = 1'b0;
    #1 chk("t6_outputs_zero_in_reset", dut_out_any, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); chk("t6_outputs_zero_held", dut_out_any, 0);
    NRST = 1'b1;
    @(posedge CLK); #1;
    rd_q.push_back('{id: 1'b0, data: 32'hDEAD_BEEF, resp: 2'b00});
    rd_q.push_back('{id: 1'b1, data: 32'h1000_000F, resp: 2'b00});
    fork mgr_read(0, 4'h4); mgr_read(1, 4'hF); join

    repeat (3) @(posedge CLK);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("wr_queue_drained", wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
